// File: rtl/belt_pkg.sv
// rtl/belt_pkg.sv - state encoding and 50 MHz default timing for the belt sequencer
package belt_pkg;

  // State codes are shown on the LEDs/7-seg, so the numeric values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam int DEF_DEBOUNCE_CYC = 500_000;      // 10 ms at 50 MHz
  localparam int DEF_SETTLE_CYC   = 25_000_000;   // 0.5 s at 50 MHz
  localparam int DEF_TIMEOUT_CYC  = 250_000_000;  // 5 s at 50 MHz
  localparam int DEF_CNT_W        = 28;

  // The item counter sticks at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/belt_sequencer_if.sv
// rtl/belt_sequencer_if.sv - button/sensor/sorter inputs and motor/status outputs of the belt sequencer
interface belt_sequencer_if;
  logic        start_btn;
  logic        stop_btn;
  logic        obj_sensor;
  logic        sort_done;
  logic        on_belt;
  logic        off_belt;
  logic        sort_req;
  logic        fault;
  logic [2:0]  state;
  logic [15:0] obj_count;

  // The sequencer side: consumes raw inputs, drives motor and status lines.
  modport master (
    input  start_btn, stop_btn, obj_sensor, sort_done,
    output on_belt, off_belt, sort_req, fault, state, obj_count
  );

  // The environment side: buttons, sensor, sorter and the motor driver.
  modport slave (
    output start_btn, stop_btn, obj_sensor, sort_done,
    input  on_belt, off_belt, sort_req, fault, state, obj_count
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, level debouncer and rising-edge event pulse
module btn_debounce
  import belt_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             stable_done;

  // Counter reaching its last value means the new level has been seen DEBOUNCE_CYC times in a row.
  assign stable_done = (cnt == CNT_W'(DEBOUNCE_CYC - 1));

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Any sample equal to the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (stable_done) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // One-cycle event in the same cycle the accepted level goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rise <= 1'b0;
    else        rise <= sync2 & ~level & stable_done;
  end

endmodule

// File: rtl/belt_sequencer.sv
// rtl/belt_sequencer.sv - conveyor sequencer FSM; optional HOLD watchdog under SORT_TIMEOUT_EN
module belt_sequencer
  import belt_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  belt_sequencer_if.master bus
);

  logic             start_ev, stop_ev, obj_ev;
  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [15:0]      obj_count_q, obj_count_n;
  logic             on_belt_q, off_belt_q, sort_req_q;
  logic             settle_done, hold_limit;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_start_db (
    .clk(clk), .rst_n(rst_n), .din(bus.start_btn), .rise(start_ev));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_stop_db (
    .clk(clk), .rst_n(rst_n), .din(bus.stop_btn), .rise(stop_ev));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_obj_db (
    .clk(clk), .rst_n(rst_n), .din(bus.obj_sensor), .rise(obj_ev));

  assign settle_done = (cnt_q == CNT_W'(SETTLE_CYC - 1));
  // Also stops the counter in HOLD so it cannot wrap while waiting indefinitely.
  assign hold_limit  = (state_q == ST_HOLD) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next state, counter and item count; stop_ev wins over everything.
  always_comb begin
    state_n     = state_q;
    obj_count_n = obj_count_q;
    case (state_q)
      ST_IDLE:   if (!stop_ev && start_ev) state_n = ST_RUN;
      ST_RUN:    if (stop_ev) state_n = ST_IDLE;
                 else if (obj_ev) state_n = ST_SETTLE;
      ST_SETTLE: if (stop_ev) state_n = ST_IDLE;
                 else if (settle_done) state_n = ST_HOLD;
      ST_HOLD: begin
        if (stop_ev) begin
          state_n = ST_IDLE;
        end else if (bus.sort_done) begin
          state_n     = ST_RUN;
          obj_count_n = sat_inc16(obj_count_q);
        end
`ifdef SORT_TIMEOUT_EN
        else if (hold_limit) begin
          state_n = ST_FAULT;
        end
`endif
      end
      ST_FAULT:  if (stop_ev) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    if (state_n != state_q)
      cnt_n = '0;
    else if (state_q == ST_SETTLE || (state_q == ST_HOLD && !hold_limit))
      cnt_n = cnt_q + CNT_W'(1);
    else
      cnt_n = cnt_q;
  end

  // State, counter and outputs all register together so outputs track the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      obj_count_q <= '0;
      on_belt_q   <= 1'b0;
      off_belt_q  <= 1'b1;
      sort_req_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      obj_count_q <= obj_count_n;
      on_belt_q   <= (state_n == ST_RUN) && (state_q != ST_RUN);
      off_belt_q  <= !((state_n == ST_RUN) || (state_n == ST_SETTLE));
      sort_req_q  <= (state_n == ST_HOLD);
    end
  end

`ifdef SORT_TIMEOUT_EN
  logic fault_q;

  // Fault level follows entry into and exit from FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_n == ST_FAULT);
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.on_belt   = on_belt_q;
  assign bus.off_belt  = off_belt_q;
  assign bus.sort_req  = sort_req_q;
  assign bus.state     = state_q;
  assign bus.obj_count = obj_count_q;

endmodule

// File: tb/tb_belt_sequencer.sv
// tb/tb_belt_sequencer.sv - self-checking bench for belt_sequencer; covers SORT_TIMEOUT_EN on or off
module tb_belt_sequencer;

  localparam int DB = 4;
  localparam int SC = 8;
  localparam int TC = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  belt_sequencer_if bus();

  belt_sequencer #(.DEBOUNCE_CYC(DB), .SETTLE_CYC(SC), .TIMEOUT_CYC(TC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];
  logic [15:0] exp_count = 16'd0;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    int         hold;
    int         gap;
    logic [2:0] st;
    logic       off;
    logic       req;
    bit         push;
  } step_t;
  step_t steps[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Every on_belt pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.on_belt === 1'b1) begin
      check("on_off_exclusive", {31'd0, bus.off_belt}, 32'd0);
      check("on_belt_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("on_belt_state", {29'd0, bus.state}, {29'd0, e.st});
        check("on_belt_count", {16'd0, bus.obj_count}, {16'd0, e.cnt});
      end
    end
  end

  task automatic press(input logic s, input logic p, input logic o, input int hold, input int gap);
    bus.start_btn  = s;
    bus.stop_btn   = p;
    bus.obj_sensor = o;
    repeat (hold) @(negedge clk);
    bus.start_btn  = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.obj_sensor = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_sort();
    bus.sort_done = 1'b1;
    @(negedge clk);
    bus.sort_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check(name, sb.size(), 32'd0);
  endtask

  task automatic start_belt();
    sb.push_back('{3'd1, exp_count});
    press(1'b1, 1'b0, 1'b0, 10, 8);
    wait_drain("start_drain");
  endtask

  task automatic obj_to_settle();
    int k = 0;
    bus.obj_sensor = 1'b1;
    while (k < 30 && bus.state !== 3'd2) begin
      @(negedge clk);
      k++;
    end
    bus.obj_sensor = 1'b0;
    check("settle_latency", k, 32'd7);
  endtask

  task automatic settle_to_hold(input int reraise_at);
    int k = 0;
    while (k < 30 && bus.state !== 3'd3) begin
      @(negedge clk);
      k++;
      if (k == reraise_at) bus.obj_sensor = 1'b1;
    end
    check("hold_latency", k, 32'd8);
    check("hold_off_belt", {31'd0, bus.off_belt}, 32'd1);
    check("hold_sort_req", {31'd0, bus.sort_req}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    steps[0] = '{"glitch",     1'b1, 1'b0, 3,  10, 3'd0, 1'b1, 1'b0, 1'b0};
    steps[1] = '{"start",      1'b1, 1'b0, 10, 8,  3'd1, 1'b0, 1'b0, 1'b1};
    steps[2] = '{"start_run",  1'b1, 1'b0, 10, 8,  3'd1, 1'b0, 1'b0, 1'b0};
    steps[3] = '{"stop_start", 1'b1, 1'b1, 10, 8,  3'd0, 1'b1, 1'b0, 1'b0};
    steps[4] = '{"restart",    1'b1, 1'b0, 10, 8,  3'd1, 1'b0, 1'b0, 1'b1};

    bus.start_btn  = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.obj_sensor = 1'b0;
    bus.sort_done  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_state",    {29'd0, bus.state}, 32'd0);
    check("rst_off_belt", {31'd0, bus.off_belt}, 32'd1);
    check("rst_on_belt",  {31'd0, bus.on_belt}, 32'd0);
    check("rst_sort_req", {31'd0, bus.sort_req}, 32'd0);
    check("rst_fault",    {31'd0, bus.fault}, 32'd0);
    check("rst_count",    {16'd0, bus.obj_count}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (steps[i].push) sb.push_back('{3'd1, exp_count});
      press(steps[i].start, steps[i].stop, 1'b0, steps[i].hold, steps[i].gap);
      check({steps[i].name, "_state"}, {29'd0, bus.state}, {29'd0, steps[i].st});
      check({steps[i].name, "_off"},   {31'd0, bus.off_belt}, {31'd0, steps[i].off});
      check({steps[i].name, "_req"},   {31'd0, bus.sort_req}, {31'd0, steps[i].req});
    end
    wait_drain("table_drain");

    pulse_sort();
    repeat (2) @(negedge clk);
    check("sort_in_run_state", {29'd0, bus.state}, 32'd1);
    check("sort_in_run_count", {16'd0, bus.obj_count}, 32'd0);

    obj_to_settle();
    settle_to_hold(0);
    exp_count = 16'd1;
    sb.push_back('{3'd1, exp_count});
    pulse_sort();
    check("sorted_state", {29'd0, bus.state}, 32'd1);
    check("sorted_off",   {31'd0, bus.off_belt}, 32'd0);
    check("sorted_req",   {31'd0, bus.sort_req}, 32'd0);
    wait_drain("sort_drain");
    check("sorted_count", {16'd0, bus.obj_count}, 32'd1);

    // A second item shows up while the first is still being centred.
    obj_to_settle();
    settle_to_hold(5);
    repeat (10) @(negedge clk);
    bus.obj_sensor = 1'b0;
    check("second_obj_state", {29'd0, bus.state}, 32'd3);
    check("second_obj_req",   {31'd0, bus.sort_req}, 32'd1);
    press(1'b0, 1'b1, 1'b0, 10, 8);
    check("stop_hold_state", {29'd0, bus.state}, 32'd0);
    check("stop_hold_off",   {31'd0, bus.off_belt}, 32'd1);

    start_belt();
    obj_to_settle();
    settle_to_hold(0);
`ifdef SORT_TIMEOUT_EN
    begin
      int k = 0;
      while (k < 60 && bus.state !== 3'd4) begin
        @(negedge clk);
        k++;
      end
      check("timeout_latency", k, 32'd32);
    end
    check("fault_level", {31'd0, bus.fault}, 32'd1);
    check("fault_off",   {31'd0, bus.off_belt}, 32'd1);
    check("fault_req",   {31'd0, bus.sort_req}, 32'd0);
    press(1'b1, 1'b0, 1'b0, 10, 8);
    check("fault_start_ignored", {29'd0, bus.state}, 32'd4);
    press(1'b0, 1'b1, 1'b0, 10, 8);
    check("fault_stop_state", {29'd0, bus.state}, 32'd0);
    check("fault_stop_fault", {31'd0, bus.fault}, 32'd0);
`else
    repeat (100) @(negedge clk);
    check("no_wd_state", {29'd0, bus.state}, 32'd3);
    check("no_wd_fault", {31'd0, bus.fault}, 32'd0);
    check("no_wd_req",   {31'd0, bus.sort_req}, 32'd1);
    press(1'b0, 1'b1, 1'b0, 10, 8);
    check("no_wd_stop_state", {29'd0, bus.state}, 32'd0);
`endif

    // Asynchronous reset while the belt is settling.
    start_belt();
    obj_to_settle();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_off_belt", {31'd0, bus.off_belt}, 32'd1);
    check("arst_state",    {29'd0, bus.state}, 32'd0);
    check("arst_on_belt",  {31'd0, bus.on_belt}, 32'd0);
    check("arst_sort_req", {31'd0, bus.sort_req}, 32'd0);
    check("arst_fault",    {31'd0, bus.fault}, 32'd0);
    check("arst_count",    {16'd0, bus.obj_count}, 32'd0);
    exp_count = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Saturation: preset the item count to all-ones, then sort once more.
    start_belt();
    obj_to_settle();
    settle_to_hold(0);
    force dut.obj_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.obj_count_q;
    @(negedge clk);
    check("preset_count", {16'd0, bus.obj_count}, 32'h0000FFFF);
    exp_count = 16'hFFFF;
    sb.push_back('{3'd1, exp_count});
    pulse_sort();
    check("sat_state", {29'd0, bus.state}, 32'd1);
    wait_drain("sat_drain");
    check("sat_count", {16'd0, bus.obj_count}, 32'h0000FFFF);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
